// File: rtl/hyper_mvblck_todram_pkg.sv
// Shared hyperfabric types for the LSAB/DRAM block movers.
// Widths, mover state encoding and the pair-aligned length helper.
package hyper_mvblck_todram_pkg;

  localparam int SEC_W  = 2;
  localparam int ADDR_W = 12;
  localparam int CNT_W  = 6;
  localparam int LEN_W  = 7;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_DRAIN1,
    ST_DRAIN2
  } mv_state_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [LEN_W-1:0]  len;
    logic [CNT_W-1:0]  words;
    logic              skip;
  } mv_xfer_t;

  // Address count rounded up to whole even-aligned pairs.
  function automatic logic [LEN_W-1:0] xfer_len(
    input logic [CNT_W-1:0] cnt,
    input logic             odd
  );
    logic [LEN_W-1:0] s;
    s = {1'b0, cnt} + LEN_W'(cnt[0] ^ odd) + LEN_W'(1);
    return {s[LEN_W-1:1], 1'b0};
  endfunction

endpackage

// File: rtl/hyper_lsab_section_sel.sv
// LSAB section selector: picks EMPTY/ERR of the active section.
// Shared by the DRAM-read and DRAM-write block movers.
module hyper_lsab_section_sel
  import hyper_mvblck_todram_pkg::*;
(
  input  logic [SEC_W-1:0] sec,
  input  logic [3:0]       empty,
  input  logic [3:0]       err,
  output logic             stop_n,
  output logic             dev_err
);

  assign dev_err = err[sec];
  assign stop_n  = !(empty[sec] || err[sec]);

endmodule

// File: rtl/hyper_mvblck_todram.sv
// Block mover: drains one LSAB section into a contiguous DRAM block
// through the shared MCU collector port, in even-aligned pairs.
module hyper_mvblck_todram
  import hyper_mvblck_todram_pkg::*;
(
  input  logic              CLK,
  input  logic              RST,
  input  logic              DEV_0_ERR,
  input  logic              DEV_1_ERR,
  input  logic              DEV_2_ERR,
  input  logic              DEV_3_ERR,
  output logic              DEV_0_ERR_ACK,
  output logic              DEV_1_ERR_ACK,
  output logic              DEV_2_ERR_ACK,
  output logic              DEV_3_ERR_ACK,
  input  logic              LSAB_0_EMPTY,
  input  logic              LSAB_1_EMPTY,
  input  logic              LSAB_2_EMPTY,
  input  logic              LSAB_3_EMPTY,
  output logic              LSAB_READ,
  output logic [SEC_W-1:0]  LSAB_SECTION,
  input  logic [ADDR_W-1:0] START_ADDRESS,
  input  logic [CNT_W-1:0]  COUNT_REQ,
  input  logic [SEC_W-1:0]  SECTION,
  input  logic [1:0]        DRAM_SEL,
  input  logic              ISSUE,
  output logic [CNT_W-1:0]  COUNT_SENT,
  output logic              WORKING,
  output logic              ABRUPT_STOP,
  output logic              DEVICE_ERROR,
  output logic [ADDR_W-1:0] MCU_COLL_ADDRESS,
  output logic              MCU_WORD_ENABLE,
  output logic [1:0]        MCU_REQUEST_ACCESS
);

  mv_state_t        state, state_nx;
  mv_xfer_t         x;
  logic [SEC_W-1:0] sec;
  logic [CNT_W-1:0] sent;
  logic             abrupt;
  logic             deverr;
  logic [3:0]       ack;

  logic stop_n;
  logic dev_err;
  logic issue_ok;
  logic accept;
  logic moving;
  logic idle;
  logic last;
  logic slot;
  logic rd;

  hyper_lsab_section_sel u_sel (
    .sec     (sec),
    .empty   ({LSAB_3_EMPTY, LSAB_2_EMPTY,
               LSAB_1_EMPTY, LSAB_0_EMPTY}),
    .err     ({DEV_3_ERR, DEV_2_ERR,
               DEV_1_ERR, DEV_0_ERR}),
    .stop_n  (stop_n),
    .dev_err (dev_err)
  );

  assign idle     = (state == ST_IDLE);
  assign moving   = (state == ST_MOVE);
  assign issue_ok = ISSUE && RST && (COUNT_REQ != '0);
  assign accept   = issue_ok && idle;
  assign last     = (x.len == LEN_W'(1));
  assign slot     = !x.skip && (x.words != '0);
  assign rd       = moving && stop_n && slot;

  always_ff @(posedge CLK) begin
    if (!RST) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:   if (accept) state_nx = ST_MOVE;
      ST_MOVE:   if (!stop_n || last) state_nx = ST_DRAIN1;
      ST_DRAIN1: state_nx = ST_DRAIN2;
      ST_DRAIN2: state_nx = ST_IDLE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      x      <= '{addr: '0, len: LEN_W'(1), words: '0, skip: 1'b0};
      sec    <= '0;
      sent   <= '0;
      abrupt <= 1'b0;
      deverr <= 1'b0;
      ack    <= '0;
    end else if (accept) begin
      x.addr  <= {START_ADDRESS[ADDR_W-1:1], 1'b0};
      x.len   <= xfer_len(COUNT_REQ, START_ADDRESS[0]);
      x.words <= COUNT_REQ;
      x.skip  <= START_ADDRESS[0];
      sec     <= SECTION;
      sent    <= '0;
      abrupt  <= 1'b0;
      deverr  <= 1'b0;
      ack     <= '0;
    end else if (moving) begin
      if (stop_n) begin
        x.skip <= 1'b0;
        if (slot) begin
          x.words <= x.words - CNT_W'(1);
          sent    <= sent + CNT_W'(1);
        end
        if (!last) begin
          x.addr <= x.addr + ADDR_W'(1);
          x.len  <= x.len - LEN_W'(1);
        end
      end else begin
        // Address stays on the word that could not be delivered.
        abrupt   <= 1'b1;
        deverr   <= dev_err;
        ack[sec] <= dev_err;
      end
    end
  end

  always_comb begin
    MCU_REQUEST_ACCESS = '0;
    if (moving)    MCU_REQUEST_ACCESS = DRAM_SEL & {2{!last}};
    else if (idle) MCU_REQUEST_ACCESS = DRAM_SEL & {2{issue_ok}};
  end

  assign LSAB_READ        = rd;
  assign MCU_WORD_ENABLE  = rd;
  assign LSAB_SECTION     = sec;
  assign MCU_COLL_ADDRESS = x.addr;
  assign COUNT_SENT       = sent;
  assign WORKING          = !idle;
  assign ABRUPT_STOP      = abrupt;
  assign DEVICE_ERROR     = deverr;
  assign DEV_0_ERR_ACK    = ack[0];
  assign DEV_1_ERR_ACK    = ack[1];
  assign DEV_2_ERR_ACK    = ack[2];
  assign DEV_3_ERR_ACK    = ack[3];

endmodule

// File: tb/tb_hyper_mvblck_todram.sv
// Bench for hyper_mvblck_todram: directed and random block moves
// compared cycle by cycle against an address-range reference model.
module tb_hyper_mvblck_todram;

  logic        CLK;
  logic        RST;
  logic [3:0]  dev_err;
  logic [3:0]  empty;
  logic [11:0] START_ADDRESS;
  logic [5:0]  COUNT_REQ;
  logic [1:0]  SECTION;
  logic [1:0]  DRAM_SEL;
  logic        ISSUE;
  logic        DEV_0_ERR_ACK, DEV_1_ERR_ACK;
  logic        DEV_2_ERR_ACK, DEV_3_ERR_ACK;
  logic        LSAB_READ;
  logic [1:0]  LSAB_SECTION;
  logic [5:0]  COUNT_SENT;
  logic        WORKING;
  logic        ABRUPT_STOP;
  logic        DEVICE_ERROR;
  logic [11:0] MCU_COLL_ADDRESS;
  logic        MCU_WORD_ENABLE;
  logic [1:0]  MCU_REQUEST_ACCESS;
  logic [3:0]  acks;

  int n_cmp = 0;
  int n_bad = 0;

  assign acks = {DEV_3_ERR_ACK, DEV_2_ERR_ACK,
                 DEV_1_ERR_ACK, DEV_0_ERR_ACK};

  hyper_mvblck_todram dut (
    .CLK                (CLK),
    .RST                (RST),
    .DEV_0_ERR          (dev_err[0]),
    .DEV_1_ERR          (dev_err[1]),
    .DEV_2_ERR          (dev_err[2]),
    .DEV_3_ERR          (dev_err[3]),
    .DEV_0_ERR_ACK      (DEV_0_ERR_ACK),
    .DEV_1_ERR_ACK      (DEV_1_ERR_ACK),
    .DEV_2_ERR_ACK      (DEV_2_ERR_ACK),
    .DEV_3_ERR_ACK      (DEV_3_ERR_ACK),
    .LSAB_0_EMPTY       (empty[0]),
    .LSAB_1_EMPTY       (empty[1]),
    .LSAB_2_EMPTY       (empty[2]),
    .LSAB_3_EMPTY       (empty[3]),
    .LSAB_READ          (LSAB_READ),
    .LSAB_SECTION       (LSAB_SECTION),
    .START_ADDRESS      (START_ADDRESS),
    .COUNT_REQ          (COUNT_REQ),
    .SECTION            (SECTION),
    .DRAM_SEL           (DRAM_SEL),
    .ISSUE              (ISSUE),
    .COUNT_SENT         (COUNT_SENT),
    .WORKING            (WORKING),
    .ABRUPT_STOP        (ABRUPT_STOP),
    .DEVICE_ERROR       (DEVICE_ERROR),
    .MCU_COLL_ADDRESS   (MCU_COLL_ADDRESS),
    .MCU_WORD_ENABLE    (MCU_WORD_ENABLE),
    .MCU_REQUEST_ACCESS (MCU_REQUEST_ACCESS)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog: run did not end");
    $fatal(1);
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_addr"}, 32'(MCU_COLL_ADDRESS), 0);
    chk({tag, "_rd"},   32'(LSAB_READ), 0);
    chk({tag, "_we"},   32'(MCU_WORD_ENABLE), 0);
    chk({tag, "_req"},  32'(MCU_REQUEST_ACCESS), 0);
    chk({tag, "_wk"},   32'(WORKING), 0);
    chk({tag, "_sec"},  32'(LSAB_SECTION), 0);
    chk({tag, "_sent"}, 32'(COUNT_SENT), 0);
    chk({tag, "_abr"},  32'(ABRUPT_STOP), 0);
    chk({tag, "_dev"},  32'(DEVICE_ERROR), 0);
    chk({tag, "_ack"},  32'(acks), 0);
  endtask

  // Model: addresses cover whole pairs around [st, st+cnt-1];
  // an address carries a word when it falls inside that range
  // and the transfer has not been stopped at or before it.
  task automatic xfer(input logic [11:0] st,
                      input logic [5:0]  cnt,
                      input logic [1:0]  sc,
                      input logic [1:0]  ds,
                      input int          stop_k,
                      input bit          stop_err,
                      input bit          busy);
    int first, lastw, n, endk, sent_e, j;
    bit ab, de, en;
    logic [3:0] ack_e;
    first = int'(st) - int'(st) % 2;
    lastw = int'(st) + int'(cnt) - 1;
    n = lastw - first + 1;
    if (n % 2 != 0) n++;
    ab = (stop_k >= 1) && (stop_k <= n);
    endk = ab ? stop_k : n;
    de = ab && stop_err;
    ack_e = de ? (4'b0001 << sc) : 4'b0000;
    sent_e = 0;

    START_ADDRESS = st;
    COUNT_REQ = cnt;
    SECTION = sc;
    DRAM_SEL = ds;
    ISSUE = 1'b1;
    @(negedge CLK);
    chk("req_c0", 32'(MCU_REQUEST_ACCESS), 32'(ds));
    @(posedge CLK); #1;
    ISSUE = busy;
    if (busy) begin
      START_ADDRESS = 12'($urandom);
      COUNT_REQ = 6'($urandom_range(1, 63));
      SECTION = 2'($urandom);
    end

    for (int k = 1; k <= endk + 2; k++) begin
      if (ab && k == stop_k) begin
        if (stop_err) dev_err[sc] = 1'b1;
        else          empty[sc] = 1'b1;
      end
      if (ab && k == stop_k + 1) dev_err = '0;
      @(negedge CLK);
      chk("working", 32'(WORKING), 1);
      chk("section", 32'(LSAB_SECTION), 32'(sc));
      if (k <= endk) begin
        j = k - 1 - int'(st) % 2;
        en = !(ab && k == stop_k) && j >= 0 && j < int'(cnt);
        chk("addr", 32'(MCU_COLL_ADDRESS),
            32'((first + k - 1) & 'hfff));
        chk("lsab_read", 32'(LSAB_READ), 32'(en));
        chk("word_en", 32'(MCU_WORD_ENABLE), 32'(en));
        chk("req", 32'(MCU_REQUEST_ACCESS),
            (k < n) ? 32'(ds) : 0);
        if (k == 1) begin
          chk("clr_sent", 32'(COUNT_SENT), 0);
          chk("clr_abr", 32'(ABRUPT_STOP), 0);
          chk("clr_dev", 32'(DEVICE_ERROR), 0);
          chk("clr_ack", 32'(acks), 0);
        end
        if (en) sent_e++;
      end else begin
        chk("drain_rd", 32'(LSAB_READ), 0);
        chk("drain_addr", 32'(MCU_COLL_ADDRESS),
            32'((first + endk - 1) & 'hfff));
        if (!busy)
          chk("drain_req", 32'(MCU_REQUEST_ACCESS), 0);
      end
      @(posedge CLK); #1;
    end

    // Earliest re-accept cycle: status must already be final.
    ISSUE = 1'b0;
    empty = '0;
    dev_err = '0;
    chk("end_working", 32'(WORKING), 0);
    chk("count_sent", 32'(COUNT_SENT), 32'(sent_e));
    chk("abrupt", 32'(ABRUPT_STOP), 32'(ab));
    chk("dev_error", 32'(DEVICE_ERROR), 32'(de));
    chk("err_ack", 32'(acks), 32'(ack_e));
  endtask

  initial begin
    RST = 1'b0;
    dev_err = '0;
    empty = '0;
    START_ADDRESS = '0;
    COUNT_REQ = '0;
    SECTION = '0;
    DRAM_SEL = '0;
    ISSUE = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk_all_zero("reset");
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    xfer(12'h010, 6'd4, 2'd0, 2'b11, 0, 1'b0, 1'b0);
    xfer(12'h011, 6'd4, 2'd0, 2'b01, 0, 1'b0, 1'b0);
    xfer(12'h020, 6'd3, 2'd0, 2'b10, 0, 1'b0, 1'b0);
    xfer(12'h040, 6'd8, 2'd1, 2'b01, 3, 1'b0, 1'b0);
    xfer(12'h100, 6'd5, 2'd2, 2'b11, 2, 1'b1, 1'b0);
    xfer(12'h104, 6'd2, 2'd3, 2'b11, 0, 1'b0, 1'b0);
    xfer(12'h001, 6'd63, 2'd1, 2'b10, 0, 1'b0, 1'b0);
    xfer(12'hFF1, 6'd63, 2'd2, 2'b11, 0, 1'b0, 1'b0);
    xfer(12'hFFF, 6'd1, 2'd3, 2'b01, 2, 1'b1, 1'b0);
    xfer(12'h300, 6'd6, 2'd1, 2'b11, 0, 1'b0, 1'b1);
    xfer(12'h031, 6'd1, 2'd0, 2'b11, 1, 1'b1, 1'b0);

    // ISSUE with a zero count is ignored.
    START_ADDRESS = 12'h005;
    COUNT_REQ = 6'd0;
    DRAM_SEL = 2'b11;
    ISSUE = 1'b1;
    @(negedge CLK);
    chk("cnt0_req", 32'(MCU_REQUEST_ACCESS), 0);
    @(posedge CLK); #1;
    ISSUE = 1'b0;
    @(negedge CLK);
    chk("cnt0_working", 32'(WORKING), 0);
    chk("cnt0_rd", 32'(LSAB_READ), 0);
    @(posedge CLK); #1;

    // Reset in cycle 3 of a 6-word transfer.
    START_ADDRESS = 12'h200;
    COUNT_REQ = 6'd6;
    SECTION = 2'd3;
    DRAM_SEL = 2'b11;
    ISSUE = 1'b1;
    @(posedge CLK); #1;
    ISSUE = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    chk("pre_rst_sent", 32'(COUNT_SENT), 1);
    @(posedge CLK); #1;
    RST = 1'b0;
    @(posedge CLK); #1;
    RST = 1'b1;
    chk_all_zero("midrst");
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      chk("midrst_rd", 32'(LSAB_READ), 0);
      chk("midrst_wk", 32'(WORKING), 0);
      @(posedge CLK); #1;
    end

    for (int t = 0; t < 24; t++) begin
      logic [11:0] st;
      logic [5:0]  cnt;
      int          sk;
      st  = 12'($urandom);
      cnt = 6'($urandom_range(1, 63));
      sk  = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 70)) : 0;
      xfer(st, cnt, 2'($urandom), 2'($urandom), sk,
           1'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hyper_mvblck_todram.md
# hyper_mvblck_todram

Block mover that drains up to 63 words from one LSAB read-side section (lsab_cr) and writes them as a contiguous block into DRAM through the shared MCU collector port. It is the DRAM-write counterpart of the DRAM-to-LSAB mover. Several movers share one MCU, so their MCU_REQUEST_ACCESS outputs are ORed together. All transfers are issued as even-aligned address pairs; padding words are suppressed with a word-enable strobe.

## Interface
- No parameters.
- CLK  in  1  clock
- RST  in  1  synchronous reset, active-low
- DEV_0_ERR..DEV_3_ERR  in  1 each  device error, per section
- DEV_0_ERR_ACK..DEV_3_ERR_ACK  out  1 each  error acknowledge, per section
- LSAB_0_EMPTY..LSAB_3_EMPTY  in  1 each  section has no readable word
- LSAB_READ  out  1  pop one word from LSAB_SECTION; data reaches MCU write path one cycle later
- LSAB_SECTION  out  2  section being drained
- START_ADDRESS  in  12  first DRAM word address
- COUNT_REQ  in  6  words to move, 1..63
- SECTION  in  2  LSAB section to drain
- DRAM_SEL  in  2  MCU request lane(s) to drive
- ISSUE  in  1  start request
- COUNT_SENT  out  6  words actually popped and written
- WORKING  out  1  transfer in progress, including data drain
- ABRUPT_STOP  out  1  last transfer ended early
- DEVICE_ERROR  out  1  early end was caused by a device error
- MCU_COLL_ADDRESS  out  12  DRAM word address
- MCU_WORD_ENABLE  out  1  current address carries a real word; low means masked padding
- MCU_REQUEST_ACCESS  out  2  combinational MCU request

## Operation
- Reset: every output 0. Internal state: am_working=0, len_left=1, counters 0.
- Length: uneven = COUNT_REQ[0]^START_ADDRESS[0]; N = {(COUNT_REQ+uneven+1)[6:1],0}, computed 7-bit. N counts addresses, always even, maximum 64.
- Accept: ISSUE is taken when am_working=0, WORKING=0, RST=1 and COUNT_REQ≠0. On accept:
  - MCU_COLL_ADDRESS = {START_ADDRESS[11:1],0}
  - len_left = N
  - skip = START_ADDRESS[0]
  - words_left = COUNT_REQ
  - LSAB_SECTION = SECTION
  - COUNT_SENT, ABRUPT_STOP, DEVICE_ERROR and all ERR_ACKs cleared
- ISSUE with COUNT_REQ=0 is ignored. No request is raised.
- stop_n = !(LSAB_x_EMPTY || DEV_x_ERR) for x = LSAB_SECTION (combinational mux).
- slot = !skip && words_left≠0.
- Working cycle with stop_n=1:
  - MCU_WORD_ENABLE = LSAB_READ = slot
  - if slot: words_left−1, COUNT_SENT+1
  - skip cleared
  - if len_left≠1: address+1, len_left−1; else am_working=0
- Working cycle with stop_n=0:
  - LSAB_READ = MCU_WORD_ENABLE = 0; address is held
  - am_working=0, ABRUPT_STOP=1, DEVICE_ERROR=DEV_x_ERR, DEV_x_ERR_ACK=DEV_x_ERR
- MCU_REQUEST_ACCESS:
  - when idle: DRAM_SEL & {2{ISSUE&&RST&&COUNT_REQ≠0}}
  - when working: DRAM_SEL & {2{len_left≠1}}
  - Deasserts one cycle early on the final address. Stays high during the stop cycle.
- WORKING: set the cycle after accept. Cleared 2 cycles after am_working falls, which covers the 1-cycle data lag.
- Status outputs are held until the next accept. ERR_ACK stays held even if DEV_x_ERR drops.
- Reset mid-transfer: all state returns to reset values on the next edge. No further LSAB_READ is issued.

## Timing
- Accept edge = cycle 0. Address k is presented in cycle 1+k; the final address in cycle N.
- LSAB_READ and MCU_WORD_ENABLE are coincident with their address. Write data follows 1 cycle later.
- WORKING is high in cycles 1..N+2.
- The earliest next accept is cycle N+3.
- ABRUPT_STOP and COUNT_SENT are valid once WORKING=0.
- LSAB must assert EMPTY no later than the cycle its last word is read.

## Structure
- Shared hyperfabric package holds:
  - section width 2
  - address width 12
  - count width 6
  - internal length width 7
- Sub-module hyper_lsab_section_sel: 4:1 mux of EMPTY/ERR that yields stop_n and dev_err. It is reusable by the DRAM-read mover.

## Test plan
- START=0x010, COUNT=4, SECTION=0, never empty:
  - addresses 0x010..0x013, all enabled
  - 4 LSAB_READs, COUNT_SENT=4
  - WORKING in cycles 1..6
  - MCU_REQUEST_ACCESS low from cycle 4
- START=0x011, COUNT=4:
  - N=6, addresses 0x010..0x015
  - enable only on 0x011..0x014
  - COUNT_SENT=4, ABRUPT_STOP=0
- START=0x020, COUNT=3:
  - N=4, enable on 0x020..0x022, 0x023 masked
  - COUNT_SENT=3
- START=0x040, COUNT=8, SECTION=1, LSAB_1_EMPTY rises in cycle 3:
  - reads in cycles 1-2 only, address held at 0x042
  - ABRUPT_STOP=1, DEVICE_ERROR=0, COUNT_SENT=2
  - WORKING falls after cycle 5
- SECTION=2, DEV_2_ERR asserted in cycle 2:
  - DEV_2_ERR_ACK=1, DEVICE_ERROR=1, ABRUPT_STOP=1, COUNT_SENT=1
  - other ACKs remain 0
  - next ISSUE clears all three status flags
- Edge cases:
  - RST low in cycle 3 of a 6-word transfer: all outputs 0 on the next edge, no LSAB_READ afterwards
  - COUNT_REQ=0 with ISSUE: no request, WORKING stays 0
  - ISSUE while WORKING=1: ignored
